// File: rtl/cpu_ctrl_fsm_pkg.sv
// cpu_ctrl_pkg: opcodes, ALU codes and FSM states shared by the control unit, ALU and bench
package cpu_ctrl_pkg;
  localparam logic [3:0] OPC_ADD   = 4'b0000;
  localparam logic [3:0] OPC_SUB   = 4'b0001;
  localparam logic [3:0] OPC_LOAD  = 4'b0100;
  localparam logic [3:0] OPC_STORE = 4'b0101;
  localparam logic [3:0] OPC_JUMP  = 4'b1000;
  localparam logic [3:0] OPC_BEQ   = 4'b1101;
  localparam logic [3:0] OPC_BGT   = 4'b1110;
  localparam logic [3:0] OPC_BLT   = 4'b1111;
  localparam logic [3:0] ALU_ADD   = 4'b1000;
  localparam logic [3:0] ALU_SUB   = 4'b0010;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// cpu_ctrl_fsm_if: fetch handshake, RAM/ALU/register-file/PC controls of the control unit
interface cpu_ctrl_fsm_if #(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int REG_AW  = 2,
  parameter int ADDR_W  = 8
);
  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic               instr_ready;
  logic               branch_check;
  logic               mem_ready;
  logic [OPC_W-1:0]   alu_code;
  logic               ram_read;
  logic               ram_write;
  logic [ADDR_W-1:0]  ram_adr;
  logic               reg_read;
  logic               reg_write;
  logic [REG_AW-1:0]  reg1;
  logic [REG_AW-1:0]  reg2;
  logic               pc_inc;
  logic               pc_jump;
  logic               pc_branch;
  logic               illegal;
  logic               mem_err;
  modport master (
    input  instr_valid, instruction, branch_check, mem_ready,
    output instr_ready, alu_code, ram_read, ram_write, ram_adr, reg_read, reg_write,
           reg1, reg2, pc_inc, pc_jump, pc_branch, illegal, mem_err
  );
  modport slave (
    output instr_valid, instruction, branch_check, mem_ready,
    input  instr_ready, alu_code, ram_read, ram_write, ram_adr, reg_read, reg_write,
           reg1, reg2, pc_inc, pc_jump, pc_branch, illegal, mem_err
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle fetch/decode/execute/memory/writeback control unit for the 16-bit CPU
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int OPC_W       = 4,
  parameter int REG_AW      = 2,
  parameter int ADDR_W      = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst_n,
  cpu_ctrl_fsm_if.master bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  state_t              r_state, w_state_nxt;
  logic [INSTR_W-1:0]  r_ir;
  logic [CW-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [OPC_W-1:0]    w_opc;
  logic [REG_AW-1:0]   w_rs1, w_rs2;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_add, w_sub, w_ld, w_st, w_jmp, w_br, w_alu, w_legal, w_timeout;
  assign w_opc     = r_ir[INSTR_W-1 -: OPC_W];
  assign w_rs1     = r_ir[INSTR_W-OPC_W-1 -: REG_AW];
  assign w_rs2     = r_ir[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
  assign w_addr    = r_ir[ADDR_W-1:0];
  assign w_add     = w_opc == OPC_W'(OPC_ADD);
  assign w_sub     = w_opc == OPC_W'(OPC_SUB);
  assign w_ld      = w_opc == OPC_W'(OPC_LOAD);
  assign w_st      = w_opc == OPC_W'(OPC_STORE);
  assign w_jmp     = w_opc == OPC_W'(OPC_JUMP);
  assign w_br      = w_opc == OPC_W'(OPC_BEQ) || w_opc == OPC_W'(OPC_BGT) || w_opc == OPC_W'(OPC_BLT);
  assign w_alu     = w_add || w_sub;
  assign w_legal   = w_alu || w_ld || w_st || w_jmp || w_br;
  assign w_cnt_inc = r_cnt + 1'b1;
  // the access has used up its budget when this MEM cycle brings the count to MEM_TIMEOUT
  assign w_timeout = w_cnt_inc == CW'(MEM_TIMEOUT);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_ir    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == FETCH && bus.instr_valid) r_ir <= bus.instruction;
    end
  end
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    bus.instr_ready = 1'b0;
    bus.alu_code    = '0;
    bus.ram_read    = 1'b0;
    bus.ram_write   = 1'b0;
    bus.ram_adr     = '0;
    bus.reg_read    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.reg1        = '0;
    bus.reg2        = '0;
    bus.pc_inc      = 1'b0;
    bus.pc_jump     = 1'b0;
    bus.pc_branch   = 1'b0;
    bus.illegal     = 1'b0;
    bus.mem_err     = 1'b0;
    if (rst_n) begin
      case (r_state)
        FETCH: begin
          bus.instr_ready = 1'b1;
          w_state_nxt     = bus.instr_valid ? DECODE : FETCH;
        end
        DECODE: begin
          bus.reg1     = w_rs1;
          bus.reg2     = w_rs2;
          bus.reg_read = w_alu || w_st || w_br;
          bus.illegal  = !w_legal;
          bus.pc_inc   = !w_legal;
          w_state_nxt  = w_legal ? EXEC : FETCH;
        end
        EXEC: begin
          if (w_alu) begin
            bus.alu_code = w_add ? OPC_W'(ALU_ADD) : OPC_W'(ALU_SUB);
            bus.reg1     = w_rs1;
            bus.reg2     = w_rs2;
            w_state_nxt  = WB;
          end else if (w_ld || w_st) begin
            bus.ram_adr   = w_addr;
            bus.ram_read  = w_ld;
            bus.ram_write = w_st;
            w_cnt_nxt     = '0;
            w_state_nxt   = MEM;
          end else begin
            bus.pc_jump   = w_jmp;
            bus.alu_code  = w_br ? w_opc : '0;
            bus.reg1      = w_br ? w_rs1 : '0;
            bus.reg2      = w_br ? w_rs2 : '0;
            bus.pc_branch = w_br && bus.branch_check;
            bus.pc_inc    = w_br && !bus.branch_check;
            bus.ram_adr   = (w_jmp || bus.branch_check) ? w_addr : '0;
            w_state_nxt   = FETCH;
          end
        end
        MEM: begin
          bus.ram_adr   = w_addr;
          bus.ram_read  = w_ld;
          bus.ram_write = w_st;
          w_cnt_nxt     = w_cnt_inc;
          bus.mem_err   = !bus.mem_ready && w_timeout;
          bus.pc_inc    = bus.mem_ready ? w_st : w_timeout;
          w_state_nxt   = bus.mem_ready ? (w_ld ? WB : FETCH) : (w_timeout ? FETCH : MEM);
        end
        WB: begin
          bus.reg_write = 1'b1;
          bus.reg1      = w_rs1;
          bus.pc_inc    = 1'b1;
          w_state_nxt   = FETCH;
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed scoreboard bench for cpu_ctrl_fsm
module tb_cpu_ctrl_fsm;
  import cpu_ctrl_pkg::*;
  typedef struct packed {
    logic       rdy;
    logic [3:0] alu;
    logic       rr;
    logic       rw;
    logic [7:0] adr;
    logic       gr;
    logic       gw;
    logic [1:0] r1;
    logic [1:0] r2;
    logic       inc;
    logic       jmp;
    logic       br;
    logic       ill;
    logic       err;
  } outs_t;
  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  outs_t obs;
  outs_t exp_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  cpu_ctrl_fsm_if bus ();
  cpu_ctrl_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  assign obs = {bus.instr_ready, bus.alu_code, bus.ram_read, bus.ram_write, bus.ram_adr,
                bus.reg_read, bus.reg_write, bus.reg1, bus.reg2, bus.pc_inc, bus.pc_jump,
                bus.pc_branch, bus.illegal, bus.mem_err};
  function automatic outs_t o(logic rdy = 0, logic [3:0] alu = 0, logic rr = 0, logic rw = 0,
                              logic [7:0] adr = 0, logic gr = 0, logic gw = 0, logic [1:0] r1 = 0,
                              logic [1:0] r2 = 0, logic inc = 0, logic jmp = 0, logic br = 0,
                              logic ill = 0, logic err = 0);
    return '{rdy, alu, rr, rw, adr, gr, gw, r1, r2, inc, jmp, br, ill, err};
  endfunction
  task automatic ex(input outs_t e);
    exp_q.push_back(e);
  endtask
  task automatic drive(input string tag, input logic v, input logic bc, input logic mr);
    outs_t e;
    bus.instr_valid  = v;
    bus.branch_check = bc;
    bus.mem_ready    = mr;
    #1;
    n_chk++;
    if (exp_q.size() == 0) $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    else begin
      e = exp_q.pop_front();
      assert (obs === e) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
    @(negedge clk);
  endtask
  initial begin
    bus.instr_valid  = 1'b0;
    bus.instruction  = '0;
    bus.branch_check = 1'b0;
    bus.mem_ready    = 1'b0;
    @(negedge clk);
    bus.instruction = 16'h0600;
    ex(o()); drive("reset0", 1, 1, 1);
    ex(o()); drive("reset1", 1, 1, 1);
    rst_n = 1'b1;
    ex(o(.rdy(1))); drive("idle0", 0, 0, 0);
    ex(o(.rdy(1))); drive("idle1", 0, 0, 0);
    ex(o(.rdy(1))); drive("add_fetch", 1, 0, 0);
    ex(o(.gr(1), .r1(1), .r2(2))); drive("add_decode", 0, 0, 0);
    ex(o(.alu(ALU_ADD), .r1(1), .r2(2))); drive("add_exec", 0, 0, 0);
    ex(o(.gw(1), .r1(1), .inc(1))); drive("add_wb", 0, 0, 0);
    bus.instruction = 16'h1600;
    ex(o(.rdy(1))); drive("sub_fetch", 1, 0, 0);
    ex(o(.gr(1), .r1(1), .r2(2))); drive("sub_decode", 0, 0, 0);
    ex(o(.alu(ALU_SUB), .r1(1), .r2(2))); drive("sub_exec", 0, 0, 0);
    ex(o(.gw(1), .r1(1), .inc(1))); drive("sub_wb", 0, 0, 0);
    bus.instruction = 16'h4C5A;
    ex(o(.rdy(1))); drive("ld_fetch", 1, 0, 0);
    ex(o(.r1(3))); drive("ld_decode", 0, 0, 0);
    ex(o(.rr(1), .adr(8'h5A))); drive("ld_exec_ready_ignored", 0, 0, 1);
    ex(o(.rr(1), .adr(8'h5A))); drive("ld_mem1", 0, 0, 0);
    ex(o(.rr(1), .adr(8'h5A))); drive("ld_mem2", 0, 0, 0);
    ex(o(.rr(1), .adr(8'h5A))); drive("ld_mem3", 0, 0, 1);
    ex(o(.gw(1), .r1(3), .inc(1))); drive("ld_wb", 0, 0, 0);
    bus.instruction = 16'h5C5A;
    ex(o(.rdy(1))); drive("st_to_fetch", 1, 0, 0);
    ex(o(.gr(1), .r1(3))); drive("st_to_decode", 0, 0, 0);
    ex(o(.rw(1), .adr(8'h5A))); drive("st_to_exec", 0, 0, 0);
    for (int i = 1; i < 15; i++) begin
      ex(o(.rw(1), .adr(8'h5A))); drive("st_to_wait", 0, 0, 0);
    end
    ex(o(.rw(1), .adr(8'h5A), .inc(1), .err(1))); drive("st_to_timeout", 0, 0, 0);
    ex(o(.rdy(1))); drive("st_late_fetch", 1, 0, 0);
    ex(o(.gr(1), .r1(3))); drive("st_late_decode", 0, 0, 0);
    ex(o(.rw(1), .adr(8'h5A))); drive("st_late_exec", 0, 0, 0);
    for (int i = 1; i < 15; i++) begin
      ex(o(.rw(1), .adr(8'h5A))); drive("st_late_wait", 0, 0, 0);
    end
    ex(o(.rw(1), .adr(8'h5A), .inc(1))); drive("st_late_ready_at_limit", 0, 0, 1);
    bus.instruction = 16'hD120;
    ex(o(.rdy(1))); drive("beq_t_fetch", 1, 0, 0);
    ex(o(.gr(1), .r2(1))); drive("beq_t_decode", 0, 0, 0);
    ex(o(.alu(OPC_BEQ), .r2(1), .br(1), .adr(8'h20))); drive("beq_taken", 0, 1, 0);
    ex(o(.rdy(1))); drive("beq_n_fetch", 1, 0, 0);
    ex(o(.gr(1), .r2(1))); drive("beq_n_decode", 0, 1, 0);
    ex(o(.alu(OPC_BEQ), .r2(1), .inc(1))); drive("beq_not_taken", 0, 0, 0);
    bus.instruction = 16'hE7AB;
    ex(o(.rdy(1))); drive("bgt_fetch", 1, 0, 0);
    ex(o(.gr(1), .r1(1), .r2(3))); drive("bgt_decode", 0, 0, 0);
    ex(o(.alu(OPC_BGT), .r1(1), .r2(3), .br(1), .adr(8'hAB))); drive("bgt_taken", 0, 1, 0);
    bus.instruction = 16'h8033;
    ex(o(.rdy(1))); drive("jmp_fetch", 1, 0, 0);
    ex(o()); drive("jmp_decode", 0, 0, 0);
    ex(o(.jmp(1), .adr(8'h33))); drive("jmp_exec", 0, 0, 0);
    bus.instruction = 16'h3000;
    ex(o(.rdy(1))); drive("ill_fetch", 1, 0, 0);
    ex(o(.ill(1), .inc(1))); drive("ill_decode", 0, 0, 0);
    bus.instruction = 16'h4C5A;
    ex(o(.rdy(1))); drive("rst_ld_fetch", 1, 0, 0);
    ex(o(.r1(3))); drive("rst_ld_decode", 0, 0, 0);
    ex(o(.rr(1), .adr(8'h5A))); drive("rst_ld_exec", 0, 0, 0);
    ex(o(.rr(1), .adr(8'h5A))); drive("rst_ld_mem1", 0, 0, 0);
    rst_n = 1'b0;
    ex(o()); drive("rst_mid_mem", 0, 0, 1);
    rst_n = 1'b1;
    ex(o(.rdy(1))); drive("rst_after_fetch", 0, 0, 1);
    ex(o(.rdy(1))); drive("rst_after_idle", 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
